crypto1_key_collector: RTL and testbench
========================================

// Module: crypto1_key_collector
// PURPOSE
//  Downstream of each Crypto1Core search core. Deserialises the core's candidate-key bitstream (KEY_DATA/KEY_VALID) into 48-bit keys.
//  Buffers candidates in a small first-word-fall-through FIFO and hands them to the shared final-check bus via valid/ready.
//  Tracks the core's DONE, candidate count, drops and protocol errors, so the top level knows when a core's partition is exhausted.
// PARAMETERS
//  KEY_W      48  candidate key width (bits per key)
//  FIFO_DEPTH 4   candidate FIFO entries; power of two, >=2
//  CNT_W      8   width of CAND_CNT and DROP_CNT (saturating)
// PORTS
//  CLK         in   1      clock, all logic rising-edge
//  RESET       in   1      synchronous, active-high reset
//  KEY_DATA    in   1      serial candidate bit from core, MSB first
//  KEY_VALID   in   1      KEY_DATA qualifier; one bit consumed per high cycle
//  DONE        in   1      core search complete (level; sampled on rising transition)
//  OUT_KEY     out  KEY_W  FIFO head candidate
//  OUT_VALID   out  1      OUT_KEY valid (FIFO non-empty)
//  OUT_READY   in   1      downstream accepts OUT_KEY when OUT_VALID&OUT_READY
//  SEARCH_DONE out  1      DONE seen AND FIFO empty AND no partial key
//  CAND_CNT    out  CNT_W  keys successfully pushed, saturates at all-ones
//  DROP_CNT    out  CNT_W  keys dropped on full FIFO, saturates
//  ERR         out  1      sticky: DONE rose while partial key held
// BEHAVIOUR
//  Reset: all outputs 0; shift reg, bit counter, FIFO ptrs, counters, done/ERR flags cleared. Any in-flight partial key discarded.
//  Deserialiser: shift <= {shift[KEY_W-2:0],KEY_DATA} on KEY_VALID; bit_cnt 0..KEY_W-1.
//   KEY_VALID need not be contiguous; gaps hold state.
//  Key complete: cycle N where KEY_VALID=1 and bit_cnt==KEY_W-1. Assembled key = {shift[KEY_W-2:0],KEY_DATA}. bit_cnt wraps to 0 same cycle.
//  Push at edge ending cycle N. If FIFO was empty: OUT_VALID=1, OUT_KEY=key in cycle N+1 (1-cycle latency).
//  FIFO full at push: if OUT_VALID&OUT_READY same cycle, push succeeds (simultaneous pop+push). Otherwise key dropped, DROP_CNT+1, FIFO unchanged.
//  Pop: OUT_VALID&OUT_READY; next entry (or OUT_VALID=0) visible next cycle. OUT_KEY stable while OUT_VALID&!OUT_READY.
//  Push+pop on empty FIFO: not possible (OUT_VALID=0); key lands, visible next cycle.
//  CAND_CNT increments on every successful push; saturates, no wrap.
//  State machine (ctl): IDLE -> COLLECT on first KEY_VALID; COLLECT -> DRAIN on DONE rise; DRAIN -> FIN when FIFO empty.
//   FIN holds until RESET. DONE rise in IDLE goes straight to DRAIN.
//  DONE rise with bit_cnt!=0: partial key discarded, bit_cnt<=0, ERR<=1 (sticky until RESET).
//  KEY_VALID in DRAIN/FIN: bits ignored; ERR<=1.
//  DONE rise and key-complete in the same cycle: the key is pushed (not partial), no ERR.
//  SEARCH_DONE=1 only in FIN; registered, asserted the cycle after FIFO empties in DRAIN.
//  FIFO pointers: log2(FIFO_DEPTH)+1 bits; full/empty from MSB compare; wrap-around natural.
// TESTING
//  T1 48 contiguous bits of 0x27568d75631f MSB first, READY=1 -> OUT_KEY=0x27568d75631f, OUT_VALID exactly 1 cycle after last bit; CAND_CNT=1.
//  T2 same key with random 0-3 cycle gaps in KEY_VALID -> identical OUT_KEY; no extra/missing bits.
//  T3 READY=0, push 5 keys (0x1..0x5), depth 4 -> FIFO holds 1..4, DROP_CNT=1, CAND_CNT=4; then READY=1 pops 1,2,3,4 in order.
//  T4 FIFO full, 5th key completes in the same cycle as a pop -> key 5 accepted, DROP_CNT=0, order preserved.
//  T5 DONE rises after 20 bits -> partial discarded, ERR=1, SEARCH_DONE=1 once FIFO drained; DONE+48th bit same cycle -> key pushed, ERR=0.
//  T6 RESET mid-key (bit 30) and with 2 keys queued -> all outputs 0 next cycle; fresh 48-bit key afterwards captured correctly.

Source files
------------

// File: rtl/crypto1_key_collector_if.sv
// Candidate-key link between a Crypto1 search core, its key collector and the shared
// final-check bus: serial key bits and DONE in, parallel keys out via valid/ready.
interface crypto1_key_collector_if #(
  parameter int KEY_W = 48
);
  logic             key_data;
  logic             key_valid;
  logic             done;
  logic [KEY_W-1:0] out_key;
  logic             out_valid;
  logic             out_ready;

  // master: the collector itself; slave: core + downstream consumer side
  modport master (
    input  key_data, key_valid, done, out_ready,
    output out_key, out_valid
  );
  modport slave (
    output key_data, key_valid, done, out_ready,
    input  out_key, out_valid
  );
endinterface

// File: rtl/crypto1_key_collector.sv
// Deserialises a search core's candidate-key bitstream into KEY_W-bit keys, buffers them
// in a small FWFT FIFO for the final-check bus and tracks DONE, counts and protocol errors.
module crypto1_key_collector #(
  parameter int KEY_W      = 48,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  crypto1_key_collector_if.master bus,
  output logic                 o_search_done,
  output logic [CNT_W-1:0]     o_cand_cnt,
  output logic [CNT_W-1:0]     o_drop_cnt,
  output logic                 o_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(KEY_W);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [KEY_W-2:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_done_d;
  logic             r_err;
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [KEY_W-1:0] r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] r_cand_cnt, r_drop_cnt;

  logic             w_collecting, w_bit_en, w_complete, w_done_rise, w_abort;
  logic             w_empty, w_full, w_pop, w_push, w_drop;
  logic [KEY_W-1:0] w_key;

  assign w_collecting = (r_state == S_IDLE) || (r_state == S_COLLECT);
  assign w_bit_en     = bus.key_valid & w_collecting;
  assign w_complete   = w_bit_en & (r_bit_cnt == BW'(KEY_W - 1));
  assign w_key        = {r_shift, bus.key_data};
  assign w_done_rise  = bus.done & ~r_done_d;
  // A DONE rise that coincides with the final bit still yields a whole key.
  assign w_abort      = w_done_rise & w_collecting & ~w_complete;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & bus.out_ready;
  assign w_push  = w_complete & (~w_full | w_pop);
  assign w_drop  = w_complete & w_full & ~w_pop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_done_rise)        w_state_nxt = S_DRAIN;
        else if (bus.key_valid) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: if (w_done_rise) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_empty)     w_state_nxt = S_FIN;
      S_FIN:     w_state_nxt = S_FIN;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_done_d  <= 1'b0;
    end else begin
      r_done_d <= bus.done;
      if (w_abort) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_bit_en) begin
        r_shift   <= w_key[KEY_W-2:0];
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_key;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cand_cnt <= '0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push && r_cand_cnt != '1) r_cand_cnt <= r_cand_cnt + 1'b1;
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      // Sticky: partial key lost to DONE, or bits arriving after the partition ended.
      if ((w_abort && r_bit_cnt != '0) || (bus.key_valid && !w_collecting))
        r_err <= 1'b1;
    end
  end

  // Head is masked while empty so stale entries never leak onto the bus.
  assign bus.out_key   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.out_valid = ~w_empty;
  assign o_search_done = (r_state == S_FIN);
  assign o_cand_cnt    = r_cand_cnt;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_crypto1_key_collector.sv
// Bench for crypto1_key_collector: vector table, directed corner sequences and a random
// run, all compared every cycle against a queue-based reference model.
module tb_crypto1_key_collector;
  localparam int KEY_W = 48;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic d_kv = 1'b0, d_kd = 1'b0, d_done = 1'b0, d_rdy = 1'b0;
  logic             sd, err;
  logic [CNT_W-1:0] cand, drop;

  crypto1_key_collector_if #(.KEY_W(KEY_W)) bus ();
  assign bus.key_valid = d_kv;
  assign bus.key_data  = d_kd;
  assign bus.done      = d_done;
  assign bus.out_ready = d_rdy;

  crypto1_key_collector #(.KEY_W(KEY_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_search_done(sd), .o_cand_cnt(cand), .o_drop_cnt(drop), .o_err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: keys as a queue, bit accumulator, plain flags for "DONE seen" / "finished".
  logic [KEY_W-1:0] m_q[$];
  logic [KEY_W-1:0] m_acc;
  int  m_nbits, m_cand, m_drop;
  bit  m_done_prev, m_done_seen, m_fin, m_err;

  task automatic model_reset();
    m_q.delete();
    m_acc = '0; m_nbits = 0; m_cand = 0; m_drop = 0;
    m_done_prev = 0; m_done_seen = 0; m_fin = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit pop, rise, complete, draining, was_empty;
    int nb0;
    logic [KEY_W-1:0] key;
    if (rst) begin model_reset(); return; end
    draining  = m_done_seen && !m_fin;
    was_empty = (m_q.size() == 0);
    pop       = !was_empty && d_rdy;
    rise      = d_done && !m_done_prev;
    m_done_prev = d_done;
    nb0 = m_nbits;
    complete = 0;
    key = '0;
    if (d_kv) begin
      if (m_done_seen) m_err = 1;
      else begin
        m_acc = {m_acc[KEY_W-2:0], d_kd};
        m_nbits++;
        if (m_nbits == KEY_W) begin complete = 1; key = m_acc; m_nbits = 0; end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (complete) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(key);
        if (m_cand < 255) m_cand++;
      end else if (m_drop < 255) m_drop++;
    end
    if (rise && !m_done_seen) begin
      if (!complete) begin
        if (nb0 != 0) m_err = 1;
        m_nbits = 0;
      end
      m_done_seen = 1;
    end
    if (draining && was_empty) m_fin = 1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) chk("m_key", 64'(bus.out_key), 64'(m_q[0]));
    chk("m_cand", 64'(cand), 64'(m_cand));
    chk("m_drop", 64'(drop), 64'(m_drop));
    chk("m_err",  64'(err),  64'(m_err));
    chk("m_sdone", 64'(sd),  64'(m_fin));
  endtask

  // Inputs change at negedge; model steps on the same values the DUT samples.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    d_kv = 0; d_done = 0; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic send_bits(logic [KEY_W-1:0] key, int hi, int lo, int gap_max);
    for (int i = hi; i >= lo; i--) begin
      repeat ($urandom_range(0, gap_max)) begin d_kv = 0; tick(); end
      d_kv = 1; d_kd = key[i];
      tick();
    end
    d_kv = 0;
  endtask

  task automatic pop_expect(logic [KEY_W-1:0] k, string name);
    chk(name, 64'(bus.out_key), 64'(k));
    d_rdy = 1; tick(); d_rdy = 0;
  endtask

  typedef struct {
    logic [KEY_W-1:0] key;
    int               gap;
    logic [KEY_W-1:0] exp_key;
    int               exp_cand;
  } vec_t;
  vec_t vt[4];

  initial begin
    logic [KEY_W-1:0] k;
    vt[0] = '{48'h27568d75631f, 0, 48'h27568d75631f, 1};
    vt[1] = '{48'h27568d75631f, 3, 48'h27568d75631f, 1};
    vt[2] = '{48'hffffffffffff, 1, 48'hffffffffffff, 1};
    vt[3] = '{48'h800000000001, 2, 48'h800000000001, 1};
    model_reset();

    @(negedge clk);
    rst = 1; tick(); rst = 0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_key",   64'(bus.out_key),   64'd0);
    chk("rst_cand",  64'(cand), 64'd0);
    chk("rst_err",   64'(err),  64'd0);

    // T1/T2 style: single keys, contiguous and gapped
    foreach (vt[i]) begin
      do_reset();
      d_rdy = 1;
      send_bits(vt[i].key, KEY_W-1, 1, vt[i].gap);
      chk("vec_prevalid", 64'(bus.out_valid), 64'd0);
      send_bits(vt[i].key, 0, 0, vt[i].gap);
      chk("vec_valid", 64'(bus.out_valid), 64'd1);
      chk("vec_key",   64'(bus.out_key), 64'(vt[i].exp_key));
      chk("vec_cand",  64'(cand), 64'(vt[i].exp_cand));
      tick();
      chk("vec_popped", 64'(bus.out_valid), 64'd0);
      d_rdy = 0;
    end

    // T3: overflow drops the fifth key
    do_reset();
    for (int i = 1; i <= 5; i++) send_bits(48'(i), KEY_W-1, 0, 0);
    chk("t3_drop", 64'(drop), 64'd1);
    chk("t3_cand", 64'(cand), 64'd4);
    for (int i = 1; i <= 4; i++) pop_expect(48'(i), "t3_order");
    chk("t3_empty", 64'(bus.out_valid), 64'd0);

    // T4: fifth key completes on the same edge as a pop
    do_reset();
    for (int i = 1; i <= 4; i++) send_bits(48'(i), KEY_W-1, 0, 0);
    k = 48'd5;
    send_bits(k, KEY_W-1, 1, 0);
    d_kv = 1; d_kd = k[0]; d_rdy = 1; tick(); d_kv = 0; d_rdy = 0;
    chk("t4_drop", 64'(drop), 64'd0);
    chk("t4_cand", 64'(cand), 64'd5);
    for (int i = 2; i <= 5; i++) pop_expect(48'(i), "t4_order");

    // T5a: DONE after 20 bits with one key queued
    do_reset();
    send_bits(48'ha5a5_5a5a_c3c3, KEY_W-1, 0, 0);
    send_bits(48'h123456789abc, KEY_W-1, KEY_W-20, 0);
    d_done = 1; tick();
    chk("t5_err",   64'(err), 64'd1);
    chk("t5_sd0",   64'(sd),  64'd0);
    d_rdy = 1; tick();
    chk("t5_sd1",   64'(sd),  64'd0);
    tick();
    chk("t5_sdfin", 64'(sd),  64'd1);
    d_rdy = 0;

    // T5b: DONE rises with the 48th bit
    do_reset();
    k = 48'hcafe_f00d_beef;
    send_bits(k, KEY_W-1, 1, 0);
    d_kv = 1; d_kd = k[0]; d_done = 1; tick(); d_kv = 0;
    chk("t5b_err",  64'(err), 64'd0);
    chk("t5b_cand", 64'(cand), 64'd1);
    chk("t5b_key",  64'(bus.out_key), 64'(k));

    // T6: reset mid-key with two keys queued
    do_reset();
    send_bits(48'h111111111111, KEY_W-1, 0, 0);
    send_bits(48'h222222222222, KEY_W-1, 0, 0);
    send_bits(48'h333333333333, KEY_W-1, KEY_W-30, 0);
    rst = 1; tick(); rst = 0;
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_key",   64'(bus.out_key), 64'd0);
    chk("t6_cand",  64'(cand), 64'd0);
    chk("t6_sd",    64'(sd), 64'd0);
    k = 48'h0badc0ffee00;
    send_bits(k, KEY_W-1, 0, 1);
    chk("t6_fresh", 64'(bus.out_key), 64'(k));
    chk("t6_cnt",   64'(cand), 64'd1);

    // Random episodes against the model
    for (int ep = 0; ep < 6; ep++) begin
      int rdy_pct, done_at;
      do_reset();
      rdy_pct = (ep % 3 == 0) ? 5 : (ep % 3 == 1) ? 40 : 90;
      done_at = $urandom_range(400, 1000);
      for (int c = 0; c < 1100; c++) begin
        d_kv   = ($urandom_range(0, 99) < 60);
        d_kd   = 1'($urandom);
        d_rdy  = ($urandom_range(0, 99) < rdy_pct);
        d_done = (c >= done_at) && (c < done_at + 30 || c > done_at + 50);
        tick();
      end
    end
    d_kv = 0; d_done = 0; d_rdy = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
